sysbus_arbiter: RTL

//  Shares the single main Sysbus port of top between NREQ bus masters, for example the
//  va_to_pa page walker, instruction fetch and data access.
//  - Grants are round-robin and one-hot. The owner keeps the bus for a whole transaction.
//  - Request-side signals come from the owner only. Response-side signals go to the owner only.
//  - Replaces the stub bus_controller. Sits between the masters and the top-level bus ports.

---
 rtl/sysbus_arb_pkg.sv | 12 +
 rtl/sysbus_arbiter_rr_picker.sv | 29 ++
 rtl/sysbus_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/sysbus_arb_pkg.sv
// Shared types for the Sysbus arbiter.
// Imported by the picker and the arbiter top.
package sysbus_arb_pkg;

   typedef enum logic {
      IDLE,
      GRANT
   } arb_state_t;

   localparam int NREQ_MAX = 8;

endpackage

// File: rtl/sysbus_arbiter_rr_picker.sv
// Round-robin winner search over a request vector.
// Searches last+1 .. last circularly; purely combinational.
module rr_picker #(
   parameter int NREQ = 2,
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IW-1:0]   i_last,
   output logic [IW-1:0]   o_winner,
   output logic            o_valid
);

   int w_idx;

   // Walk from farthest to nearest so the nearest hit wins.
   always_comb begin
      o_valid  = 1'b0;
      o_winner = '0;
      w_idx    = 0;
      for (int k = NREQ; k >= 1; k--) begin
         w_idx = (int'(i_last) + k) % NREQ;
         if (i_req[IW'(w_idx)]) begin
            o_valid  = 1'b1;
            o_winner = IW'(w_idx);
         end
      end
   end

endmodule

// File: rtl/sysbus_arbiter.sv
// Round-robin owner arbitration of the single main Sysbus port.
// The owner keeps the bus until it drops reqcyc or times out.
module sysbus_arbiter
   import sysbus_arb_pkg::*;
#(
   parameter int NREQ           = 2,
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int TIMEOUT        = 1023
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic [NREQ-1:0]                            m_reqcyc,
   input  logic [NREQ-1:0][BUS_DATA_WIDTH-1:0]        m_req,
   input  logic [NREQ-1:0][BUS_TAG_WIDTH-1:0]         m_reqtag,
   input  logic [NREQ-1:0]                            m_respack,
   output logic [NREQ-1:0]                            m_grant,
   output logic [NREQ-1:0]                            m_reqack,
   output logic [NREQ-1:0]                            m_respcyc,
   output logic [BUS_DATA_WIDTH-1:0]                  m_resp,
   output logic [BUS_TAG_WIDTH-1:0]                   m_resptag,
   output logic                                       busy,
   output logic                                       timeout_err,
   output logic                                       bus_reqcyc,
   output logic [BUS_DATA_WIDTH-1:0]                  bus_req,
   output logic [BUS_TAG_WIDTH-1:0]                   bus_reqtag,
   output logic                                       bus_respack,
   input  logic                                       bus_reqack,
   input  logic                                       bus_respcyc,
   input  logic [BUS_DATA_WIDTH-1:0]                  bus_resp,
   input  logic [BUS_TAG_WIDTH-1:0]                   bus_resptag
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   arb_state_t      r_state, w_state_nxt;
   logic [NREQ-1:0] r_grant, w_grant_nxt;
   logic [IW-1:0]   r_last,  w_last_nxt;
   logic [CW-1:0]   r_hold,  w_hold_nxt;
   logic            r_terr,  w_terr_nxt;

   logic [IW-1:0]   w_pick_win;
   logic            w_pick_vld;
   logic            w_busy;
   logic            w_own_req;

   rr_picker #(.NREQ(NREQ)) u_picker (
      .i_req    (m_reqcyc),
      .i_last   (r_last),
      .o_winner (w_pick_win),
      .o_valid  (w_pick_vld)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_grant <= '0;
         r_last  <= IW'(NREQ - 1);
         r_hold  <= '0;
         r_terr  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_last  <= w_last_nxt;
         r_hold  <= w_hold_nxt;
         r_terr  <= w_terr_nxt;
      end
   end

   // r_last doubles as the owner index while in GRANT.
   assign w_busy    = |r_grant;
   assign w_own_req = m_reqcyc[r_last];

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_last_nxt  = r_last;
      w_hold_nxt  = r_hold;
      w_terr_nxt  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_pick_vld) begin
               w_state_nxt = GRANT;
               w_grant_nxt = NREQ'(1) << w_pick_win;
               w_last_nxt  = w_pick_win;
               w_hold_nxt  = '0;
            end
         end
         GRANT: begin
            if (!w_own_req) begin
               w_state_nxt = IDLE;
               w_grant_nxt = '0;
            end else if (TIMEOUT != 0 && r_hold == CW'(TIMEOUT)) begin
               w_state_nxt = IDLE;
               w_grant_nxt = '0;
               w_terr_nxt  = 1'b1;
            end else if (r_hold != {CW{1'b1}}) begin
               w_hold_nxt = r_hold + 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
         end
      endcase
   end

   assign m_grant     = r_grant;
   assign busy        = w_busy;
   assign timeout_err = r_terr;

   assign bus_reqcyc  = w_own_req & w_busy;
   assign bus_req     = w_busy ? m_req[r_last] : '0;
   assign bus_reqtag  = w_busy ? m_reqtag[r_last] : '0;
   assign bus_respack = m_respack[r_last] & w_busy;

   assign m_reqack  = {NREQ{bus_reqack}} & r_grant;
   assign m_respcyc = {NREQ{bus_respcyc}} & r_grant;
   assign m_resp    = bus_resp;
   assign m_resptag = bus_resptag;

   a_grant_onehot: assert property (
      @(posedge clk) disable iff (!reset) $onehot0(r_grant)
   );

   a_nreq_range: assert property (
      @(posedge clk) (NREQ >= 2) && (NREQ <= NREQ_MAX)
   );

endmodule
